// File: rtl/parking_gate_ctrl.sv
// Multi-lane parking entry barrier controller with shared slot reservation and occupancy tracking.
// Define GATE_TIMEOUT_EN to close an open barrier after OPEN_CYCLES cycles without a vehicle passing.
module parking_gate_ctrl #(
    parameter int unsigned       NUM_LANES   = 4,
    parameter int unsigned       CODE_W      = 2,
    parameter logic [CODE_W-1:0] GRANT_CODE  = '1,
    parameter int unsigned       CAPACITY    = 16,
    parameter int unsigned       OPEN_CYCLES = 100
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           st,
    input  logic [NUM_LANES*CODE_W-1:0]    code,
    input  logic [NUM_LANES-1:0]           car_pass,
    input  logic                           exit_pass,
    output logic [NUM_LANES-1:0]           open,
    output logic [NUM_LANES-1:0]           done,
    output logic [NUM_LANES-1:0]           deny,
    output logic [$clog2(CAPACITY+1)-1:0]  occupancy,
    output logic                           full
);
    localparam int unsigned OCC_W = $clog2(CAPACITY + 1);

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} lane_state_e;

    lane_state_e          state_q [NUM_LANES];
    lane_state_e          state_d [NUM_LANES];
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 full_q, full_d;
    logic [NUM_LANES-1:0] grant_c;
    int unsigned          open_cnt, open_cnt_d, free_slots, req_cnt, entries;

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TMR_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    logic [TMR_W-1:0] tmr_q [NUM_LANES];
    logic [TMR_W-1:0] tmr_d [NUM_LANES];
`endif

    if (OPEN_CYCLES < 1) begin : g_bad_cfg
        $error("OPEN_CYCLES must be at least 1");
    end

    // Lane FSMs, ascending-index slot arbitration and occupancy bookkeeping
    always_comb begin
        open_cnt = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            open_cnt = open_cnt + 32'(state_q[i] == OPEN);
        end
        // Open lanes hold a reserved slot, so occupancy can never overshoot CAPACITY
        free_slots = CAPACITY - 32'(occ_q) - open_cnt;
        req_cnt    = 0;
        entries    = 0;
        grant_c    = '0;
        done       = '0;
        deny       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
`ifdef GATE_TIMEOUT_EN
            tmr_d[i] = tmr_q[i];
`endif
            case (state_q[i])
                IDLE: begin
                    if (st[i]) begin
                        done[i] = 1'b1;
                        if (code[i*CODE_W +: CODE_W] == GRANT_CODE) begin
                            grant_c[i] = (req_cnt < free_slots);
                            req_cnt    = req_cnt + 1;
                        end
                        deny[i] = !grant_c[i];
                        if (grant_c[i]) begin
                            state_d[i] = OPEN;
`ifdef GATE_TIMEOUT_EN
                            tmr_d[i] = TMR_W'(OPEN_CYCLES - 1);
`endif
                        end
                    end
                end
                OPEN: begin
                    if (car_pass[i]) begin
                        state_d[i] = IDLE;
                        entries    = entries + 1;
                    end
`ifdef GATE_TIMEOUT_EN
                    else if (tmr_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TMR_W'(1);
                    end
`endif
                end
            endcase
        end

        occ_d = occ_q + OCC_W'(entries);
        if (exit_pass && (occ_q != '0)) begin
            occ_d = occ_d - OCC_W'(1);
        end

        open_cnt_d = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            open_cnt_d = open_cnt_d + 32'(state_d[i] == OPEN);
        end
        full_d = ((CAPACITY - 32'(occ_d) - open_cnt_d) == 0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= IDLE;
            end
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
            end
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

`ifdef GATE_TIMEOUT_EN
    // Per-lane open-window counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                tmr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_open
        assign open[g] = (state_q[g] == OPEN);
    end

    assign occupancy = occ_q;
    assign full      = full_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_parking_gate_ctrl;
    localparam int unsigned NL  = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned CAP = 16;
    localparam int unsigned OC  = 4;
    localparam int unsigned OW  = $clog2(CAP + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [NL-1:0]     st, car_pass, open, done, deny;
    logic [NL*CW-1:0]  code;
    logic              exit_pass, full;
    logic [OW-1:0]     occupancy;

    parking_gate_ctrl #(
        .NUM_LANES(NL), .CODE_W(CW), .GRANT_CODE(2'b11), .CAPACITY(CAP), .OPEN_CYCLES(OC)
    ) dut (
        .clk(clk), .reset(reset), .st(st), .code(code), .car_pass(car_pass),
        .exit_pass(exit_pass), .open(open), .done(done), .deny(deny),
        .occupancy(occupancy), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        string         tag;
        logic [NL-1:0] done;
        logic [NL-1:0] deny;
        logic [NL-1:0] open;
        logic [OW-1:0] occ;
        logic          full;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [NL-1:0] s, input logic [NL*CW-1:0] c,
                         input logic [NL-1:0] cp, input logic ex);
        @(posedge clk);
        #1;
        st = s; code = c; car_pass = cp; exit_pass = ex;
    endtask

    task automatic expect_now(input string tag, input logic [NL-1:0] d, input logic [NL-1:0] dn,
                              input logic [NL-1:0] op, input int oc, input logic f);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.done = d; e.deny = dn; e.open = op; e.occ = OW'(oc); e.full = f;
        sb.push_back(e);
    endtask

    task automatic fill(input int from, input int to);
        for (int k = from; k < to; k++) begin
            drive(4'b0001, 8'hFF, 4'b0000, 1'b0);
            expect_now("fill_req", 4'b0001, 4'b0000, 4'b0000, k, 1'b0);
            drive(4'b0000, 8'h00, 4'b0001, 1'b0);
            expect_now("fill_pass", 4'b0000, 4'b0000, 4'b0001, k, 1'b0);
        end
    endtask

    // Monitor: compare every expectation due in the current cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                if (e.cyc != cyc) begin
                    $display("FAIL %s: expectation for cycle %0d left unchecked until cycle %0d", e.tag, e.cyc, cyc);
                end else if ({done, deny, open, occupancy, full} !== {e.done, e.deny, e.open, e.occ, e.full}) begin
                    $display("FAIL %s @%0d: got done=%b deny=%b open=%b occ=%0d full=%b, want done=%b deny=%b open=%b occ=%0d full=%b",
                             e.tag, cyc, done, deny, open, occupancy, full, e.done, e.deny, e.open, e.occ, e.full);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; st = '0; code = '0; car_pass = '0; exit_pass = 1'b0;
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("in_reset", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        drive(4'b0001, 8'hFF, 4'b0000, 1'b0);
        expect_now("grant_l0", 4'b0001, 4'b0000, 4'b0000, 0, 1'b0);
        drive(4'b0001, 8'hFF, 4'b0000, 1'b0);
        expect_now("open_ignores_st", 4'b0000, 4'b0000, 4'b0001, 0, 1'b0);
        drive(4'b0000, 8'h00, 4'b0001, 1'b0);
        expect_now("open_until_pass", 4'b0000, 4'b0000, 4'b0001, 0, 1'b0);
        drive(4'b0010, 8'hF7, 4'b0000, 1'b0);
        expect_now("deny_bad_code", 4'b0010, 4'b0010, 4'b0000, 1, 1'b0);
        drive(4'b0000, 8'h00, 4'b1111, 1'b0);
        expect_now("stay_idle_after_deny", 4'b0000, 4'b0000, 4'b0000, 1, 1'b0);
        drive(4'b0000, 8'h00, 4'b0000, 1'b1);
        expect_now("car_pass_idle_ignored", 4'b0000, 4'b0000, 4'b0000, 1, 1'b0);
        drive(4'b0000, 8'h00, 4'b0000, 1'b1);
        expect_now("exit_decrements", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("exit_at_zero", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);

        fill(0, 5);
        drive(4'b1000, 8'hFF, 4'b0000, 1'b0);
        expect_now("grant_l3", 4'b1000, 4'b0000, 4'b0000, 5, 1'b0);
        drive(4'b0000, 8'h00, 4'b1000, 1'b1);
        expect_now("l3_open", 4'b0000, 4'b0000, 4'b1000, 5, 1'b0);
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("entry_exit_net", 4'b0000, 4'b0000, 4'b0000, 5, 1'b0);

        fill(5, 15);
        drive(4'b0101, 8'hFF, 4'b0000, 1'b0);
        expect_now("last_slot_priority", 4'b0101, 4'b0100, 4'b0000, 15, 1'b0);
        drive(4'b0100, 8'hFF, 4'b0000, 1'b0);
        expect_now("reserved_full", 4'b0100, 4'b0100, 4'b0001, 15, 1'b1);
        drive(4'b0000, 8'h00, 4'b0001, 1'b0);
        expect_now("full_open_hold", 4'b0000, 4'b0000, 4'b0001, 15, 1'b1);
        drive(4'b0010, 8'hFF, 4'b0000, 1'b1);
        expect_now("at_capacity", 4'b0010, 4'b0010, 4'b0000, 16, 1'b1);
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("exit_from_full", 4'b0000, 4'b0000, 4'b0000, 15, 1'b0);

        drive(4'b0010, 8'hFF, 4'b0000, 1'b0);
        expect_now("grant_l1", 4'b0010, 4'b0000, 4'b0000, 15, 1'b0);
        for (int j = 0; j < 8; j++) begin
            drive(4'b0000, 8'h00, 4'b0000, 1'b0);
`ifdef GATE_TIMEOUT_EN
            if (j < 4) expect_now("timeout_window", 4'b0000, 4'b0000, 4'b0010, 15, 1'b1);
            else       expect_now("timeout_closed", 4'b0000, 4'b0000, 4'b0000, 15, 1'b0);
`else
            expect_now("open_persists", 4'b0000, 4'b0000, 4'b0010, 15, 1'b1);
`endif
        end
`ifndef GATE_TIMEOUT_EN
        drive(4'b0000, 8'h00, 4'b0010, 1'b0);
        expect_now("late_pass", 4'b0000, 4'b0000, 4'b0010, 15, 1'b1);
        drive(4'b0000, 8'h00, 4'b0000, 1'b1);
        expect_now("late_entry", 4'b0000, 4'b0000, 4'b0000, 16, 1'b1);
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("late_exit", 4'b0000, 4'b0000, 4'b0000, 15, 1'b0);
`endif

        drive(4'b0001, 8'hFF, 4'b0000, 1'b0);
        expect_now("grant_before_reset", 4'b0001, 4'b0000, 4'b0000, 15, 1'b0);
        drive(4'b0000, 8'h00, 4'b0000, 1'b0);
        expect_now("open_before_reset", 4'b0000, 4'b0000, 4'b0001, 15, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        expect_now("reset_mid_open", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b0000, 8'h00, 4'b0001, 1'b0);
        expect_now("after_reset", 4'b0000, 4'b0000, 4'b0000, 0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
